// File: rtl/digit_emitter_if.sv
// Bundles the request side and the token stream of the digit emitter.
// The master drives a conversion request and consumes tokens; the slave is the emitter.
interface digit_emitter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] number;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_token;
    logic             out_last;

    modport master (
        output start, number, out_ready,
        input  busy, out_valid, out_token, out_last
    );

    modport slave (
        input  start, number, out_ready,
        output busy, out_valid, out_token, out_last
    );
endinterface

// File: rtl/digit_emitter.sv
// Converts a two's-complement number to decimal by repeated restoring division by 10,
// then streams the sign and digits (most significant first) over a valid/ready handshake.
module digit_emitter #(
    parameter int         WIDTH       = 32,
    parameter int         MAX_DIGITS  = 10,
    parameter logic [3:0] MINUS_TOKEN = 4'hB
) (
    input logic            clk,
    input logic            reset,
    digit_emitter_if.slave bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIVIDE, EMIT} state_t;

    state_t           state_q;
    logic             neg_q;
    logic [WIDTH-1:0] mag_q;
    logic [WIDTH-1:0] quot_q;
    logic [3:0]       rem_q;
    logic [BW-1:0]    bitCnt_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    ptr_q;
    logic [3:0]       buf_q [MAX_DIGITS];
    logic             busy_q;
    logic             valid_q;
    logic             last_q;
    logic [3:0]       token_q;

    logic [4:0]       trial;
    logic             geTen;
    logic [3:0]       rem_d;
    logic [WIDTH-1:0] quot_d;
    logic [WIDTH-1:0] magAbs;

    // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign magAbs = bus.number[WIDTH-1] ? (WIDTH'(0) - bus.number) : bus.number;

    always_comb begin
        trial  = {rem_q, mag_q[bitCnt_q]};
        geTen  = (trial >= 5'd10);
        rem_d  = geTen ? 4'(trial - 5'd10) : trial[3:0];
        quot_d = quot_q;
        quot_d[bitCnt_q] = geTen;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            neg_q    <= 1'b0;
            mag_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            bitCnt_q <= '0;
            count_q  <= '0;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            token_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        neg_q    <= bus.number[WIDTH-1];
                        mag_q    <= magAbs;
                        quot_q   <= '0;
                        rem_q    <= '0;
                        bitCnt_q <= BW'(WIDTH - 1);
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= DIVIDE;
                    end
                end

                DIVIDE: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    if (bitCnt_q == '0) begin
                        buf_q[count_q] <= rem_d;
                        count_q        <= count_q + CW'(1);
                        if (quot_d == '0) begin
                            // The digit just produced is the most significant, so it can be shown directly.
                            state_q <= EMIT;
                            valid_q <= 1'b1;
                            if (neg_q) begin
                                token_q <= MINUS_TOKEN;
                                last_q  <= 1'b0;
                                ptr_q   <= count_q;
                            end else begin
                                token_q <= rem_d;
                                last_q  <= (count_q == '0);
                                ptr_q   <= count_q - CW'(1);
                            end
                        end else begin
                            mag_q    <= quot_d;
                            quot_q   <= '0;
                            rem_q    <= '0;
                            bitCnt_q <= BW'(WIDTH - 1);
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q - BW'(1);
                    end
                end

                EMIT: begin
                    if (valid_q && bus.out_ready) begin
                        if (last_q) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            token_q <= buf_q[ptr_q];
                            last_q  <= (ptr_q == '0);
                            ptr_q   <= ptr_q - CW'(1);
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.out_token = token_q;
    assign bus.out_last  = last_q;
endmodule

// File: tb/tb_digit_emitter.sv
// Directed self-checking bench for digit_emitter: latency, token order, stalls,
// ignored start requests and synchronous reset in the middle of a conversion.
module tb_digit_emitter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    digit_emitter_if #(.WIDTH(32)) bus ();

    digit_emitter #(
        .WIDTH      (32),
        .MAX_DIGITS (10),
        .MINUS_TOKEN(4'hB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulses start for one edge; returns at the negedge right after the accepting edge.
    task automatic applyStimulus(input logic [31:0] num);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.number = num;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic waitValid(input string tag, input int expLatency);
        int cnt;
        cnt = 0;
        while (bus.out_valid !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput({tag, "_latency"}, 32'(cnt), 32'(expLatency));
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
    endtask

    // Tokens are packed most significant first in seq; stall holds out_ready low per token.
    task automatic emitCheck(input string tag, input logic [47:0] seq, input int n,
                             input int stall, input bit pulseStart);
        logic [3:0] exp;
        for (int i = 0; i < n; i++) begin
            exp = seq[4*(n-1-i) +: 4];
            if (stall > 0) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    bus.start  = (pulseStart && i == 0 && s == 2);
                    bus.number = 32'd11;
                    checkOutput({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
                    checkOutput({tag, "_hold_token"}, 32'(bus.out_token), 32'(exp));
                    @(negedge clk);
                end
                bus.start     = 1'b0;
                bus.out_ready = 1'b1;
            end
            checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
            checkOutput({tag, "_token"}, 32'(bus.out_token), 32'(exp));
            checkOutput({tag, "_last"}, 32'(bus.out_last), 32'(i == n - 1));
            checkOutput({tag, "_busy_emit"}, 32'(bus.busy), 32'd1);
            @(negedge clk);
        end
        checkOutput({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.number    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_last", 32'(bus.out_last), 32'd0);
        checkOutput("rst_token", 32'(bus.out_token), 32'd0);
        reset = 1'b0;

        applyStimulus(32'd1234);
        waitValid("n1234", 128);
        emitCheck("n1234", 48'h1234, 4, 0, 1'b0);

        applyStimulus(32'd0);
        waitValid("n0", 32);
        emitCheck("n0", 48'h0, 1, 0, 1'b0);

        applyStimulus(32'hFFFF_FFF9);
        waitValid("m7", 32);
        emitCheck("m7", 48'hB7, 2, 0, 1'b0);

        applyStimulus(32'h8000_0000);
        waitValid("min", 320);
        emitCheck("min", 48'hB_2147483648, 11, 0, 1'b0);

        applyStimulus(32'd905);
        waitValid("n905", 96);
        emitCheck("n905", 48'h905, 3, 5, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("n905_idle_busy", 32'(bus.busy), 32'd0);
            checkOutput("n905_idle_valid", 32'(bus.out_valid), 32'd0);
        end

        applyStimulus(32'd56);
        repeat (39) @(negedge clk);
        checkOutput("n56_busy_pre", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("n56_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("n56_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("n56_rst_last", 32'(bus.out_last), 32'd0);
        checkOutput("n56_rst_token", 32'(bus.out_token), 32'd0);

        applyStimulus(32'd3);
        waitValid("n3", 32);
        emitCheck("n3", 48'h3, 1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
